// File: rtl/mult_digit_serial_ctrl.sv
// Digit-serial signed/unsigned multiplier: one 2x2 signed/unsigned slice is stepped over
// every (a digit, b digit) pair and the shifted partial products are accumulated.
module mult_digit_serial_ctrl #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 busy
);

    localparam int unsigned NA = A_WIDTH / 2;
    localparam int unsigned NB = B_WIDTH / 2;
    localparam int unsigned IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int unsigned JW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] ILast = IW'(NA - 1);
    localparam logic [JW-1:0] JLast = JW'(NB - 1);

    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

    state_e                 state_q, state_d;
    logic [A_WIDTH-1:0]     a_q, a_d;
    logic [B_WIDTH-1:0]     b_q, b_d;
    logic                   a_signed_q, a_signed_d;
    logic                   b_signed_q, b_signed_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [IW-1:0]          i_q, i_d;
    logic [JW-1:0]          j_q, j_d;

    logic [1:0]             a_dig, b_dig;
    logic [1:0]             sign_mode;
    logic signed [2:0]      a_ext, b_ext;
    logic signed [5:0]      prod;
    logic signed [4:0]      slice_out;
    logic signed [OUT_WIDTH-1:0] pp_ext;
    logic [OUT_WIDTH-1:0]   pp_shift;
    logic [31:0]            shamt;

    // 2x2 slice: only the top digit of a signed operand carries the sign.
    always_comb begin
        a_dig        = a_q[{i_q, 1'b0} +: 2];
        b_dig        = b_q[{j_q, 1'b0} +: 2];
        sign_mode[0] = a_signed_q && (i_q == ILast);
        sign_mode[1] = b_signed_q && (j_q == JLast);
        a_ext        = {sign_mode[0] & a_dig[1], a_dig};
        b_ext        = {sign_mode[1] & b_dig[1], b_dig};
        prod         = 6'(a_ext) * 6'(b_ext);
        slice_out    = prod[4:0];
        pp_ext       = OUT_WIDTH'(slice_out);
        shamt        = (32'(i_q) + 32'(j_q)) << 1;
        pp_shift     = pp_ext << shamt;
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        a_signed_d = a_signed_q;
        b_signed_d = b_signed_q;
        acc_d      = acc_q;
        i_d        = i_q;
        j_d        = j_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    a_signed_d = a_signed;
                    b_signed_d = b_signed;
                    acc_d      = '0;
                    i_d        = '0;
                    j_d        = '0;
                    state_d    = StCompute;
                end
            end
            StCompute: begin
                acc_d = acc_q + pp_shift;
                if (i_q == ILast) begin
                    i_d = '0;
                    if (j_q == JLast) begin
                        j_d     = '0;
                        state_d = StDone;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            a_signed_q <= 1'b0;
            b_signed_q <= 1'b0;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            a_signed_q <= a_signed_d;
            b_signed_q <= b_signed_d;
            acc_q      <= acc_d;
            i_q        <= i_d;
            j_q        <= j_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !reset;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out       = acc_q;

endmodule
